matmul_array_seq: RTL
=====================

// Module: matmul_array_seq
// PURPOSE
//  Parametrised NxN unsigned matrix multiplier C = A x B; successor to the fixed 3x3 8-bit multiplier.
//  N*N parallel MAC cells; one k-index per cycle, all cells fed in parallel, so a product completes in N cycles.
//  Start/ready request side, valid/ready result side; sits between operand buffers and the result sink.
// PARAMETERS
//  N       3                      matrix dimension (>=1)
//  DATA_W  8                      element width of A and B (unsigned)
//  ACC_W   2*DATA_W+$clog2(N+1)   internal accumulator width; never overflows
//  OUT_W   8                      width of each c element
// PORTS
//  clk       in   1             clock, rising edge
//  reset     in   1             asynchronous, active-high
//  start     in   1             request; accepted when start && in_ready
//  in_ready  out  1             high only in IDLE
//  a_flat    in   N*N*DATA_W    A[i][k] at bits [(i*N+k)*DATA_W +: DATA_W]
//  b_flat    in   N*N*DATA_W    B[k][j], same packing
//  c_flat    out  N*N*OUT_W     C[i][j] at bits [(i*N+j)*OUT_W +: OUT_W]
//  c_valid   out  1             c_flat holds a finished product
//  c_ready   in   1             sink accepts; transfer on c_valid && c_ready
//  busy      out  1             high in RUN
//  ovf       out  1             >=1 element of the current result exceeded OUT_W
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, k=0, accumulators=0, c_flat=0, c_valid=0, busy=0, ovf=0, in_ready=1.
//  FSM states: IDLE, RUN, DONE.
//  IDLE: in_ready=1. At edge t with start=1: latch a_flat/b_flat into operand regs, clear all accumulators and ovf, k=0, go RUN.
//   start=0: stay. a_flat/b_flat changes after edge t have no effect on the result.
//  RUN: busy=1, in_ready=0. Each edge: acc[i][j] += A[i][k]*B[k][j] (full 2*DATA_W product, zero-extended to ACC_W).
//   k increments. On the edge where k==N-1: final accumulate, register c_flat from the final sums, set ovf, c_valid=1, go DONE.
//   Latency: c_valid rises exactly N edges after the accepting edge (N=1: one edge).
//   start during RUN/DONE: ignored; not queued.
//  DONE: c_valid=1; c_flat and ovf are held stable.
//   Edge with c_ready=1: c_valid=0, go IDLE. A new start is accepted no earlier than the following edge.
//   c_ready=0: hold indefinitely.
//   c_ready in IDLE/RUN: ignored.
//  c_flat and ovf change only on the RUN->DONE edge or on reset.
//  Width rule: ovf = OR over all cells of (acc[i][j] > 2^OUT_W-1).
//  Reset mid-RUN or mid-DONE: the result is discarded, c_valid drops immediately (async), no partial output.
// CONFIGURATION
//  MATMUL_SAT_EN defined: each c element = min(acc, 2^OUT_W-1), saturating at all-ones.
//  MATMUL_SAT_EN undefined: each c element = acc[OUT_W-1:0], wrapping modulo 2^OUT_W.
//  ovf behaves identically in both builds.
// TESTING
//  T1 identity, N=3: A=I, B=[1..9] row-major, start 1 cycle
//     -> c_valid after exactly 3 edges; C=[1..9]; ovf=0.
//  T2 overflow: A=B=all 0xFF
//     -> acc=3*65025=195075, ovf=1. Elements = 0xFF with MATMUL_SAT_EN, 0x03 (195075 mod 256) without.
//  T3 backpressure: c_ready=0 for 10 cycles after c_valid
//     -> c_flat/ovf stable, in_ready=0, start pulses ignored. c_ready=1 -> IDLE next edge, in_ready=1.
//  T4 operand isolation: change a_flat/b_flat and pulse start during RUN
//     -> result equals product of the operands latched at acceptance; exactly one c_valid.
//  T5 reset mid-RUN: assert reset at k=1
//     -> all outputs 0 asynchronously, in_ready=1. Fresh start then gives a correct result with normal latency.
//  T6 back-to-back: c_ready tied 1, start tied 1, N=3
//     -> products accepted every 5 cycles (accept, 3 RUN edges, DONE edge); each result correct.

Source files
------------

// File: rtl/matmul_array_seq.sv
// matmul_array_seq: NxN unsigned matrix multiplier, N*N parallel MAC cells, one k per cycle.
// Build option MATMUL_SAT_EN: saturate each c element at all-ones instead of wrapping.
module matmul_array_seq #(
   parameter int N      = 3,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 2*DATA_W+$clog2(N+1),
   parameter int OUT_W  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic                    in_ready,
   input  logic [N*N*DATA_W-1:0]   a_flat,
   input  logic [N*N*DATA_W-1:0]   b_flat,
   output logic [N*N*OUT_W-1:0]    c_flat,
   output logic                    c_valid,
   input  logic                    c_ready,
   output logic                    busy,
   output logic                    ovf
);

   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N-1);
   localparam int PW = 2*DATA_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [KW-1:0]      r_k;
   logic [DATA_W-1:0]  r_a   [N][N];
   logic [DATA_W-1:0]  r_b   [N][N];
   logic [ACC_W-1:0]   r_acc [N][N];
   logic [N*N*OUT_W-1:0] r_c;
   logic               r_ovf;

   logic [PW-1:0]      w_prod [N][N];
   logic [ACC_W-1:0]   w_sum  [N][N];
   logic [N*N*OUT_W-1:0] w_c;
   logic               w_ovf;
   logic               w_accept;
   logic               w_last;

   // State register; reset drops any result in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next state and handshake outputs, all decoded from the state
   always_comb begin
      w_next   = r_state;
      in_ready = 1'b0;
      busy     = 1'b0;
      c_valid  = 1'b0;
      w_accept = 1'b0;
      w_last   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (start) begin
               w_accept = 1'b1;
               w_next   = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (r_k == K_LAST) begin
               w_last = 1'b1;
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            c_valid = 1'b1;
            if (c_ready)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // MAC array: this cycle's partial sums and the output mapping of them
   always_comb begin
      w_c   = '0;
      w_ovf = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            w_prod[i][j] = {{DATA_W{1'b0}}, r_a[i][r_k]}
                         * {{DATA_W{1'b0}}, r_b[r_k][j]};
            w_sum[i][j]  = r_acc[i][j]
                         + {{(ACC_W-PW){1'b0}}, w_prod[i][j]};
            if (|(w_sum[i][j] >> OUT_W))
               w_ovf = 1'b1;
`ifdef MATMUL_SAT_EN
            w_c[(i*N+j)*OUT_W +: OUT_W] =
               (|(w_sum[i][j] >> OUT_W)) ? {OUT_W{1'b1}}
                                         : w_sum[i][j][OUT_W-1:0];
`else
            w_c[(i*N+j)*OUT_W +: OUT_W] = w_sum[i][j][OUT_W-1:0];
`endif
         end
      end
   end

   // Operand capture at acceptance, accumulation in RUN, result capture on the last k
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_k   <= '0;
         r_c   <= '0;
         r_ovf <= 1'b0;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               r_a[i][j]   <= '0;
               r_b[i][j]   <= '0;
               r_acc[i][j] <= '0;
            end
         end
      end else if (w_accept) begin
         r_k   <= '0;
         r_ovf <= 1'b0;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               r_a[i][j]   <= a_flat[(i*N+j)*DATA_W +: DATA_W];
               r_b[i][j]   <= b_flat[(i*N+j)*DATA_W +: DATA_W];
               r_acc[i][j] <= '0;
            end
         end
      end else if (busy) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               r_acc[i][j] <= w_sum[i][j];
            end
         end
         if (w_last) begin
            r_k   <= '0;
            r_c   <= w_c;
            r_ovf <= w_ovf;
         end else begin
            r_k <= r_k + KW'(1);
         end
      end
   end

   assign c_flat = r_c;
   assign ovf    = r_ovf;

endmodule
